// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: walks h/v over the full raster, requests pixels in the active
// window and emits registered rgb, de and sync one clock behind the counters.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 110,
    parameter int unsigned H_SYNC     = 40,
    parameter int unsigned H_BP       = 220,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned V_FP       = 5,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 20,
    parameter bit          HSYNC_POL  = 1'b1,
    parameter bit          VSYNC_POL  = 1'b1,
    parameter bit          CONTINUOUS = 1'b1,
    parameter int unsigned CW         = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [3*CW-1:0] color,
    input  logic          color_valid,
    output logic          pixel_req,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic          busy,
    output logic          underflow
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          stop_pending_q, stop_pending_d;
    logic          underflow_d;

    logic          run, h_last, v_last, in_hsync, in_vsync;
    logic          hsync_d, vsync_d, de_d, frame_start_d;
    logic [CW-1:0] red_d, green_d, blue_d;

    always_comb begin
        state_d        = state_q;
        h_d            = h_q;
        v_d            = v_q;
        stop_pending_d = stop_pending_q;
        underflow_d    = underflow;

        // Compare in 32 bits so sync windows reaching the raster end cannot truncate.
        run      = (state_q == StRun);
        h_last   = (32'(h_q) == H_TOTAL - 1);
        v_last   = (32'(v_q) == V_TOTAL - 1);
        in_hsync = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
        in_vsync = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
        pixel_req = run && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);

        de_d          = pixel_req;
        hsync_d       = (run && in_hsync) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (run && in_vsync) ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = run && (h_q == '0) && (v_q == '0);
        red_d         = '0;
        green_d       = '0;
        blue_d        = '0;
        if (pixel_req && color_valid) begin
            red_d   = color[3*CW-1 -: CW];
            green_d = color[2*CW-1 -: CW];
            blue_d  = color[CW-1 -: CW];
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    h_d         = '0;
                    v_d         = '0;
                    underflow_d = 1'b0;
                end
            end
            StRun: begin
                if (stop) stop_pending_d = 1'b1;
                if (pixel_req && !color_valid) underflow_d = 1'b1;
                if (h_last) begin
                    h_d = '0;
                    if (v_last) begin
                        v_d = '0;
                        // A stop in the final clock still counts, so no extra frame starts.
                        if (!CONTINUOUS || stop_pending_q || stop) begin
                            state_d        = StIdle;
                            stop_pending_d = 1'b0;
                        end
                    end else begin
                        v_d = v_q + VW'(1);
                    end
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            h_q            <= '0;
            v_q            <= '0;
            stop_pending_q <= 1'b0;
            underflow      <= 1'b0;
            red            <= '0;
            green          <= '0;
            blue           <= '0;
            de             <= 1'b0;
            hsync          <= ~HSYNC_POL;
            vsync          <= ~VSYNC_POL;
            frame_start    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_q            <= h_d;
            v_q            <= v_d;
            stop_pending_q <= stop_pending_d;
            underflow      <= underflow_d;
            red            <= red_d;
            green          <= green_d;
            blue           <= blue_d;
            de             <= de_d;
            hsync          <= hsync_d;
            vsync          <= vsync_d;
            frame_start    <= frame_start_d;
            busy           <= run;
        end
    end

endmodule
